// File: rtl/spmmio_tape_enc.sv
// spmmio_tape_enc: MMIO byte FIFO feeding an FM-coded TI-99 cassette waveform (tape_bit/tape_audio).
// Define TAPE_ENC_LEADER_EN to add the LEADER register (adr3) that prepends 8'h00 leader bytes.
module spmmio_tape_enc #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [11:0] CELL_RESET = 12'h880,
    parameter logic [15:0] AMPLITUDE  = 16'h4000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_3mhz_en,
    input  logic [0:1]         adr,
    input  logic               cs,
    input  logic [0:3]         sel,
    input  logic               we,
    input  logic [0:31]        d,
    output logic [0:31]        q,
    output logic signed [0:15] tape_audio,
    output logic               tape_bit,
    input  logic               cs1_cntrl
);

    localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [11:0] CELL_MIN  = 12'd16;
    localparam logic [15:0] AMP_NEG   = ~AMPLITUDE + 16'd1;

    typedef enum logic [0:0] {IDLE, SEND} state_t;

    state_t      state, state_n;
    logic        enable;
    logic [11:0] cell_len;
    logic        overflow;

    logic        wr_cs, ctrl_wr, flush, push_req, cell_wr;
    logic        push_ok, pop, full, empty, src_avail, run;
    logic [7:0]  fill;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic [11:0] cnt, cnt_n;
    logic [11:0] cell_cur, cell_cur_n;
    logic [2:0]  bitcnt, bitcnt_n;
    logic [0:7]  shreg, shreg_n;
    logic        bit_n;
    logic [15:0] audio_n;

    assign wr_cs    = cs & we;
    assign ctrl_wr  = wr_cs & (adr == 2'd0) & sel[1];
    assign flush    = ctrl_wr & d[14];
    assign push_req = wr_cs & (adr == 2'd1) & sel[3];
    assign cell_wr  = wr_cs & (adr == 2'd2) & sel[2] & sel[3];

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign fill    = 8'(count);
    // A full FIFO still accepts a byte when the encoder pops in the same clock.
    assign push_ok = push_req & ~flush & (~full | pop);
    assign run     = enable & cs1_cntrl;

`ifdef TAPE_ENC_LEADER_EN
    logic [15:0] leader_cnt;
    logic        leader_wr, leader_take;

    assign leader_wr = wr_cs & (adr == 2'd3) & sel[2] & sel[3];
    assign src_avail = ~empty | (leader_cnt != 16'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            leader_cnt <= 16'd0;
        else if (flush)
            leader_cnt <= 16'd0;
        else if (leader_wr)
            leader_cnt <= d[16:31];
        else if (leader_take)
            leader_cnt <= leader_cnt - 16'd1;
    end

    logic unused_bits;
    assign unused_bits = ^{sel[0], d[0:13]};
`else
    assign src_avail = ~empty;

    logic unused_bits;
    assign unused_bits = ^{sel[0], d[0:13], d[16:19]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable   <= 1'b0;
            cell_len <= CELL_RESET;
        end else begin
            if (ctrl_wr)
                enable <= d[15];
            if (cell_wr)
                cell_len <= (d[20:31] < CELL_MIN) ? CELL_MIN : d[20:31];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= d[24:31];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop)
                overflow <= 1'b1;
        end
    end

    // Encoder: cnt runs 0..cell_cur-1; each cell boundary toggles, a '1' also toggles at cnt==cell_cur/2.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        cell_cur_n = cell_cur;
        bitcnt_n   = bitcnt;
        shreg_n    = shreg;
        bit_n      = tape_bit;
        pop        = 1'b0;
`ifdef TAPE_ENC_LEADER_EN
        leader_take = 1'b0;
`endif
        if (clk_3mhz_en) begin
            case (state)
                IDLE: begin
                    if (run && src_avail) begin
                        state_n    = SEND;
                        cnt_n      = 12'd0;
                        bitcnt_n   = 3'd0;
                        cell_cur_n = cell_len;
                        bit_n      = ~tape_bit;
`ifdef TAPE_ENC_LEADER_EN
                        if (leader_cnt != 16'd0) begin
                            shreg_n     = 8'h00;
                            leader_take = 1'b1;
                        end else
`endif
                        begin
                            shreg_n = mem[rd_ptr];
                            pop     = 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (!run) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 12'd1;
                        if ((cnt == (cell_cur >> 1)) && shreg[0])
                            bit_n = ~tape_bit;
                        if (cnt == cell_cur - 12'd1) begin
                            cnt_n      = 12'd0;
                            cell_cur_n = cell_len;
                            shreg_n    = {shreg[1:7], 1'b0};
                            if (bitcnt != 3'd7) begin
                                bit_n    = ~tape_bit;
                                bitcnt_n = bitcnt + 3'd1;
                            end else if (src_avail) begin
                                bit_n    = ~tape_bit;
                                bitcnt_n = 3'd0;
`ifdef TAPE_ENC_LEADER_EN
                                if (leader_cnt != 16'd0) begin
                                    shreg_n     = 8'h00;
                                    leader_take = 1'b1;
                                end else
`endif
                                begin
                                    shreg_n = mem[rd_ptr];
                                    pop     = 1'b1;
                                end
                            end else begin
                                state_n = IDLE;
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        audio_n = 16'd0;
        if (state_n == SEND && cs1_cntrl)
            audio_n = bit_n ? AMPLITUDE : AMP_NEG;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 12'd0;
            cell_cur   <= CELL_RESET;
            bitcnt     <= 3'd0;
            shreg      <= 8'h00;
            tape_bit   <= 1'b0;
            tape_audio <= 16'sd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            cell_cur   <= cell_cur_n;
            bitcnt     <= bitcnt_n;
            shreg      <= shreg_n;
            tape_bit   <= bit_n;
            tape_audio <= audio_n;
        end
    end

    always_comb begin
        q = '0;
        case (adr)
            2'd0: begin
                q[15] = enable;
                q[14] = (state != IDLE);
            end
            2'd1: begin
                q[0:7] = fill;
                q[8]   = full;
                q[9]   = empty;
                q[10]  = overflow;
            end
            2'd2: q[20:31] = cell_len;
            default: begin
`ifdef TAPE_ENC_LEADER_EN
                q[16:31] = leader_cnt;
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_spmmio_tape_enc.sv
// Directed self-checking bench for spmmio_tape_enc: register map, FIFO limits and FM cell timing.
// Tape edges are logged in clk_3mhz_en tick units and compared against a per-bit cell model.
`timescale 1ns/1ps
module tb_spmmio_tape_enc;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               clk_3mhz_en = 1'b0;
    logic [0:1]         adr = '0;
    logic               cs = 1'b0;
    logic [0:3]         sel = '0;
    logic               we = 1'b0;
    logic [0:31]        d = '0;
    logic [0:31]        q;
    logic signed [0:15] tape_audio;
    logic               tape_bit;
    logic               cs1_cntrl = 1'b1;

    int   checks = 0;
    int   failures = 0;
    int   tick_no = 0;
    int   edges[$];
    logic last_bit = 1'b0;
    int   div = 0;
    logic [0:31] r;
    int   n_edges;

    spmmio_tape_enc dut (
        .clk         (clk),
        .reset       (reset),
        .clk_3mhz_en (clk_3mhz_en),
        .adr         (adr),
        .cs          (cs),
        .sel         (sel),
        .we          (we),
        .d           (d),
        .q           (q),
        .tape_audio  (tape_audio),
        .tape_bit    (tape_bit),
        .cs1_cntrl   (cs1_cntrl)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (clk_3mhz_en)
            tick_no <= tick_no + 1;

    // Tick enable every other clock; tape_bit changes are logged with the tick that caused them.
    initial forever begin
        @(negedge clk);
        if (tape_bit !== last_bit) begin
            edges.push_back(tick_no - 1);
            last_bit = tape_bit;
        end
        div = (div + 1) % 2;
        clk_3mhz_en = (div == 0);
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mmio_write(input logic [0:1] a, input logic [0:3] s, input logic [0:31] v);
        @(negedge clk);
        adr = a; sel = s; d = v; cs = 1'b1; we = 1'b1;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; sel = '0; d = '0;
    endtask

    task automatic mmio_read(input logic [0:1] a, output logic [0:31] v);
        @(negedge clk);
        adr = a;
        #1 v = q;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (edges.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, 32'(edges.size() != 0), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        logic [0:31] v;
        int n = 0;
        mmio_read(2'd0, v);
        while (v[14] && n < limit) begin
            mmio_read(2'd0, v);
            n++;
        end
        check({tag, "_idle"}, 32'(v[14]), 32'd0);
    endtask

    // Expected edges: one per cell start, plus one at L/2+1 ticks into every '1' cell.
    task automatic check_edges(input string tag, input logic [31:0] bytes, input int nb, input int len);
        int exp_e[$];
        for (int c = 0; c < 8 * nb; c++) begin
            exp_e.push_back(c * len);
            if (bytes[31 - c])
                exp_e.push_back(c * len + len / 2 + 1);
        end
        check({tag, "_count"}, 32'(edges.size()), 32'(exp_e.size()));
        if (edges.size() == exp_e.size())
            for (int k = 1; k < exp_e.size(); k++)
                check($sformatf("%s_edge%0d", tag, k), 32'(edges[k] - edges[0]), 32'(exp_e[k]));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_bit", 32'(tape_bit), 32'd0);
        check("rst_audio", {16'h0, tape_audio}, 32'h0);
        mmio_read(2'd0, r); check("rst_ctrl", r, 32'h0);
        mmio_read(2'd1, r); check("rst_data", r, 32'h0040_0000);
        mmio_read(2'd2, r); check("rst_cell", r, 32'h0000_0880);
        mmio_read(2'd3, r); check("rst_adr3", r, 32'h0);

        // A5 at the reset cell length
        edges.delete();
        mmio_write(2'd1, 4'b0001, 32'h0000_00A5);
        mmio_write(2'd0, 4'b0100, 32'h0001_0000);
        wait_start("a5");
        check("a5_bit", 32'(tape_bit), 32'd1);
        check("a5_audio", {16'h0, tape_audio}, 32'h0000_4000);
        mmio_read(2'd0, r); check("a5_busy", r, 32'h0003_0000);
        wait_idle("a5", 40000);
        check_edges("a5", 32'hA500_0000, 1, 2176);
        check("a5_idle_audio", {16'h0, tape_audio}, 32'h0);

        // cell length clamp and 16-tick cells
        mmio_write(2'd2, 4'b0011, 32'h0000_0005);
        mmio_read(2'd2, r); check("clamp_cell", r, 32'h0000_0010);
        edges.delete();
        mmio_write(2'd1, 4'b0001, 32'h0000_0080);
        wait_start("c16");
        wait_idle("c16", 2000);
        check_edges("c16", 32'h8000_0000, 1, 16);

        // FF then 00, gap-free
        mmio_write(2'd0, 4'b0100, 32'h0);
        mmio_write(2'd1, 4'b0001, 32'h0000_00FF);
        mmio_write(2'd1, 4'b0001, 32'h0000_0000);
        mmio_read(2'd1, r); check("ff00_fill", r, 32'h0200_0000);
        edges.delete();
        mmio_write(2'd0, 4'b0100, 32'h0001_0000);
        wait_start("ff00");
        check("ff00_bit", 32'(tape_bit), 32'd0);
        check("ff00_audio", {16'h0, tape_audio}, 32'h0000_C000);
        wait_idle("ff00", 2000);
        check_edges("ff00", 32'hFF00_0000, 2, 16);
        mmio_read(2'd1, r); check("ff00_empty", r, 32'h0040_0000);

        // motor drop mid-byte
        mmio_write(2'd0, 4'b0100, 32'h0);
        mmio_write(2'd1, 4'b0001, 32'h0000_00AA);
        mmio_write(2'd1, 4'b0001, 32'h0000_0055);
        mmio_write(2'd1, 4'b0001, 32'h0000_000F);
        edges.delete();
        mmio_write(2'd0, 4'b0100, 32'h0001_0000);
        wait_start("abort");
        repeat (40) @(negedge clk);
        mmio_read(2'd1, r); check("abort_fill_pre", r, 32'h0200_0000);
        cs1_cntrl = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_audio", {16'h0, tape_audio}, 32'h0);
        mmio_read(2'd0, r); check("abort_ctrl", r, 32'h0001_0000);
        mmio_read(2'd1, r); check("abort_fill", r, 32'h0200_0000);
        n_edges = edges.size();
        repeat (100) @(negedge clk);
        check("abort_hold", 32'(edges.size()), 32'(n_edges));
        mmio_write(2'd0, 4'b0100, 32'h0002_0000);
        cs1_cntrl = 1'b1;
        mmio_read(2'd1, r); check("abort_flush", r, 32'h0040_0000);

        // overflow with encoder disabled, then flush
        for (int i = 0; i < 18; i++)
            mmio_write(2'd1, 4'b0001, 32'(i));
        mmio_read(2'd1, r); check("ovf_data", r, 32'h10A0_0000);
        mmio_write(2'd0, 4'b0100, 32'h0002_0000);
        mmio_read(2'd1, r); check("ovf_flush", r, 32'h0040_0000);

`ifdef TAPE_ENC_LEADER_EN
        mmio_write(2'd3, 4'b0011, 32'h0000_0003);
        mmio_read(2'd3, r); check("leader_rd", r, 32'h0000_0003);
        edges.delete();
        mmio_write(2'd1, 4'b0001, 32'h0000_00FF);
        mmio_write(2'd0, 4'b0100, 32'h0001_0000);
        wait_start("leader");
        wait_idle("leader", 5000);
        check_edges("leader", 32'h0000_00FF, 4, 16);
        mmio_read(2'd3, r); check("leader_end", r, 32'h0);
`else
        mmio_write(2'd3, 4'b1111, 32'hFFFF_FFFF);
        mmio_read(2'd3, r); check("adr3_ignored", r, 32'h0);
        mmio_read(2'd0, r); check("adr3_ctrl", r, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
